// File: rtl/uart_hex_display.sv
// UART receiver collecting ASCII hex digits into an 8-digit buffer, shown on a multiplexed
// 7-segment display on CR. Define UART_ECHO_EN to retransmit every valid received byte on RsTx.
module uart_hex_display #(
  parameter int CLK_FREQ    = 100_000_000,
  parameter int BAUD_RATE   = 9600,
  parameter int REFRESH_DIV = 100_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       RsRx,
  output logic       RsTx,
  output logic       siganl_input,
  output logic       siganl_out,
  output logic [7:0] AN,
  output logic [6:0] SEG
);
  localparam int BAUD_DIV = CLK_FREQ / BAUD_RATE;
  localparam int HALF_DIV = BAUD_DIV / 2;
  localparam int CW       = $clog2(BAUD_DIV + 1);
  localparam int RW       = $clog2(REFRESH_DIV + 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_state_e;

  function automatic logic [6:0] hex_font(input logic [3:0] d);
    case (d)
      4'h0: hex_font = 7'h40;  4'h1: hex_font = 7'h79;
      4'h2: hex_font = 7'h24;  4'h3: hex_font = 7'h30;
      4'h4: hex_font = 7'h19;  4'h5: hex_font = 7'h12;
      4'h6: hex_font = 7'h02;  4'h7: hex_font = 7'h78;
      4'h8: hex_font = 7'h00;  4'h9: hex_font = 7'h10;
      4'hA: hex_font = 7'h08;  4'hB: hex_font = 7'h03;
      4'hC: hex_font = 7'h46;  4'hD: hex_font = 7'h21;
      4'hE: hex_font = 7'h06;  default: hex_font = 7'h0E;
    endcase
  endfunction

  logic              rx_meta_q, rx_sync_q, rx_prev_q;
  uart_state_e       rx_state_q, rx_state_d;
  logic [CW-1:0]     rx_cnt_q, rx_cnt_d;
  logic [2:0]        rx_bit_q, rx_bit_d;
  logic [7:0]        rx_shift_q, rx_shift_d;
  logic              rx_valid_q, rx_valid_d;
  logic [31:0]       hex_buf_q, hex_buf_d, disp_q, disp_d;
  logic [RW-1:0]     ref_cnt_q;
  logic [2:0]        slot_q;
  logic [7:0]        an_q;
  logic [6:0]        seg_q;
  logic [3:0]        digit;
  logic              is_hex;
  logic [3:0]        nibble;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= S_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_valid_q <= 1'b0;
      hex_buf_q  <= '0;
      disp_q     <= '0;
    end else begin
      rx_meta_q  <= RsRx;
      rx_sync_q  <= rx_meta_q;
      rx_prev_q  <= rx_sync_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_valid_q <= rx_valid_d;
      hex_buf_q  <= hex_buf_d;
      disp_q     <= disp_d;
    end
  end

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_valid_d = 1'b0;
    case (rx_state_q)
      S_IDLE: if (rx_prev_q && !rx_sync_q) begin
        rx_state_d = S_START;
        rx_cnt_d   = '0;
      end
      // Mid-start re-sample: a high line here was only a glitch.
      S_START: if (rx_cnt_q == CW'(HALF_DIV - 1)) begin
        rx_cnt_d   = '0;
        rx_bit_d   = '0;
        rx_state_d = rx_sync_q ? S_IDLE : S_DATA;
      end else rx_cnt_d = rx_cnt_q + 1'b1;
      S_DATA: if (rx_cnt_q == CW'(BAUD_DIV - 1)) begin
        rx_cnt_d   = '0;
        rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
        if (rx_bit_q == 3'd7) rx_state_d = S_STOP;
        else rx_bit_d = rx_bit_q + 1'b1;
      end else rx_cnt_d = rx_cnt_q + 1'b1;
      S_STOP: if (rx_cnt_q == CW'(BAUD_DIV - 1)) begin
        rx_cnt_d   = '0;
        rx_state_d = S_IDLE;
        rx_valid_d = rx_sync_q;
      end else rx_cnt_d = rx_cnt_q + 1'b1;
      default: rx_state_d = S_IDLE;
    endcase
  end

  always_comb begin
    is_hex = 1'b1;
    nibble = '0;
    if (rx_shift_q >= 8'h30 && rx_shift_q <= 8'h39)      nibble = 4'(rx_shift_q - 8'h30);
    else if (rx_shift_q >= 8'h41 && rx_shift_q <= 8'h46) nibble = 4'(rx_shift_q - 8'h37);
    else if (rx_shift_q >= 8'h61 && rx_shift_q <= 8'h66) nibble = 4'(rx_shift_q - 8'h57);
    else is_hex = 1'b0;
  end

  always_comb begin
    hex_buf_d = hex_buf_q;
    disp_d    = disp_q;
    if (rx_valid_q) begin
      if (is_hex) hex_buf_d = {hex_buf_q[27:0], nibble};
      else if (rx_shift_q == 8'h0D) begin
        disp_d    = hex_buf_q;
        hex_buf_d = '0;
      end
    end
  end

  assign siganl_input = (rx_state_q != S_IDLE);

  // Digit outputs are registered so reset can hold AN/SEG blank.
  assign digit = disp_q[{slot_q, 2'b00} +: 4];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ref_cnt_q <= '0;
      slot_q    <= '0;
      an_q      <= 8'hFF;
      seg_q     <= 7'h7F;
    end else begin
      an_q  <= ~(8'h01 << slot_q);
      seg_q <= hex_font(digit);
      if (ref_cnt_q == RW'(REFRESH_DIV - 1)) begin
        ref_cnt_q <= '0;
        slot_q    <= slot_q + 1'b1;
      end else begin
        ref_cnt_q <= ref_cnt_q + 1'b1;
      end
    end
  end

  assign AN  = an_q;
  assign SEG = seg_q;

`ifdef UART_ECHO_EN
  uart_state_e   tx_state_q, tx_state_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]    tx_bit_q, tx_bit_d;
  logic [7:0]    tx_shift_q, tx_shift_d;
  logic          pend_valid_q, pend_valid_d;
  logic [7:0]    pend_byte_q, pend_byte_d;
  logic          tx_load, pend_accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_q   <= S_IDLE;
      tx_cnt_q     <= '0;
      tx_bit_q     <= '0;
      tx_shift_q   <= '0;
      pend_valid_q <= 1'b0;
      pend_byte_q  <= '0;
    end else begin
      tx_state_q   <= tx_state_d;
      tx_cnt_q     <= tx_cnt_d;
      tx_bit_q     <= tx_bit_d;
      tx_shift_q   <= tx_shift_d;
      pend_valid_q <= pend_valid_d;
      pend_byte_q  <= pend_byte_d;
    end
  end

  // The pending slot frees in the same clock the transmitter takes it, so a new byte can land there.
  always_comb begin
    tx_load      = (tx_state_q == S_IDLE) && pend_valid_q;
    pend_accept  = rx_valid_q && (!pend_valid_q || tx_load);
    pend_valid_d = (pend_valid_q && !tx_load) || pend_accept;
    pend_byte_d  = pend_accept ? rx_shift_q : pend_byte_q;
    tx_state_d   = tx_state_q;
    tx_cnt_d     = tx_cnt_q;
    tx_bit_d     = tx_bit_q;
    tx_shift_d   = tx_shift_q;
    case (tx_state_q)
      S_IDLE: if (pend_valid_q) begin
        tx_state_d = S_START;
        tx_cnt_d   = '0;
        tx_shift_d = pend_byte_q;
      end
      S_START: if (tx_cnt_q == CW'(BAUD_DIV - 1)) begin
        tx_cnt_d   = '0;
        tx_bit_d   = '0;
        tx_state_d = S_DATA;
      end else tx_cnt_d = tx_cnt_q + 1'b1;
      S_DATA: if (tx_cnt_q == CW'(BAUD_DIV - 1)) begin
        tx_cnt_d   = '0;
        tx_shift_d = {1'b0, tx_shift_q[7:1]};
        if (tx_bit_q == 3'd7) tx_state_d = S_STOP;
        else tx_bit_d = tx_bit_q + 1'b1;
      end else tx_cnt_d = tx_cnt_q + 1'b1;
      S_STOP: if (tx_cnt_q == CW'(BAUD_DIV - 1)) begin
        tx_cnt_d   = '0;
        tx_state_d = S_IDLE;
      end else tx_cnt_d = tx_cnt_q + 1'b1;
      default: tx_state_d = S_IDLE;
    endcase
  end

  always_comb begin
    RsTx = 1'b1;
    if (tx_state_q == S_START)     RsTx = 1'b0;
    else if (tx_state_q == S_DATA) RsTx = tx_shift_q[0];
  end

  assign siganl_out = (tx_state_q != S_IDLE);
`else
  assign RsTx       = 1'b1;
  assign siganl_out = 1'b0;
`endif

endmodule

// File: tb/tb_uart_hex_display.sv
// Scoreboard bench for uart_hex_display: display values and echoed bytes are queued as
// stimulus is driven and checked when the display scan / TX line produces them.
module tb_uart_hex_display;
  localparam int CLK_FREQ    = 1600;
  localparam int BAUD_RATE   = 100;
  localparam int REFRESH_DIV = 8;
  localparam int B           = CLK_FREQ / BAUD_RATE;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       RsRx = 1'b1;
  logic       RsTx, siganl_input, siganl_out;
  logic [7:0] AN;
  logic [6:0] SEG;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int stop_mid_cyc = 0;
  logic [31:0] model_buf = '0;
  logic [31:0] disp_q[$];
  logic [7:0]  echo_q[$];

  uart_hex_display #(
    .CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE), .REFRESH_DIV(REFRESH_DIV)
  ) dut (
    .clk(clk), .rst_n(rst_n), .RsRx(RsRx), .RsTx(RsTx),
    .siganl_input(siganl_input), .siganl_out(siganl_out), .AN(AN), .SEG(SEG)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [6:0] font(input logic [3:0] d);
    case (d)
      4'h0: font = 7'h40;  4'h1: font = 7'h79;  4'h2: font = 7'h24;  4'h3: font = 7'h30;
      4'h4: font = 7'h19;  4'h5: font = 7'h12;  4'h6: font = 7'h02;  4'h7: font = 7'h78;
      4'h8: font = 7'h00;  4'h9: font = 7'h10;  4'hA: font = 7'h08;  4'hB: font = 7'h03;
      4'hC: font = 7'h46;  4'hD: font = 7'h21;  4'hE: font = 7'h06;  default: font = 7'h0E;
    endcase
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives one 8N1 frame plus one idle bit; valid frames update the reference model.
  task automatic send_byte(input logic [7:0] b, input logic stop);
    if (stop) begin
      echo_q.push_back(b);
      if (b >= 8'h30 && b <= 8'h39)      model_buf = {model_buf[27:0], 4'(b - 8'h30)};
      else if (b >= 8'h41 && b <= 8'h46) model_buf = {model_buf[27:0], 4'(b - 8'h37)};
      else if (b >= 8'h61 && b <= 8'h66) model_buf = {model_buf[27:0], 4'(b - 8'h57)};
      else if (b == 8'h0D) begin
        disp_q.push_back(model_buf);
        model_buf = '0;
      end
    end
    RsRx = 1'b0;
    tick(B);
    for (int i = 0; i < 8; i++) begin
      RsRx = b[i];
      if (i == 3) begin
        tick(B / 2);
        total++;
        if (siganl_input !== 1'b1) begin
          bad++;
          $display("FAIL rx_busy byte %h: siganl_input=%b expected 1", b, siganl_input);
        end
        tick(B - B / 2);
      end else tick(B);
    end
    RsRx = stop;
    tick(B / 2);
    stop_mid_cyc = cyc;
    tick(B - B / 2);
    RsRx = 1'b1;
    tick(B);
    $display("rx frame %h stop=%0b", b, stop);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b1);
  endtask

  task automatic check_display(input string name);
    logic [31:0] exp_v;
    logic [7:0]  an_exp;
    int          waited;
    bit          found;
    if (disp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s: no display value queued", name);
      return;
    end
    exp_v = disp_q.pop_front();
    for (int k = 0; k < 8; k++) begin
      an_exp = ~(8'h01 << k);
      found  = 1'b0;
      waited = 0;
      while (!found && waited < 200) begin
        @(negedge clk);
        waited++;
        if (AN === an_exp) found = 1'b1;
      end
      total++;
      if (!found) begin
        bad++;
        $display("FAIL %s digit %0d: AN stuck at %h, never %h", name, k, AN, an_exp);
      end else if (SEG !== font(exp_v[k*4 +: 4])) begin
        bad++;
        $display("FAIL %s digit %0d: SEG=%h expected %h (disp %h)", name, k, SEG,
                 font(exp_v[k*4 +: 4]), exp_v);
      end
    end
    $display("display %s expected %h", name, exp_v);
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    RsRx = 1'b1;
    tick(3);
    total++; if (RsTx !== 1'b1) begin bad++; $display("FAIL reset_tx: RsTx=%b expected 1", RsTx); end
    total++; if (AN !== 8'hFF) begin bad++; $display("FAIL reset_an: AN=%h expected ff", AN); end
    total++; if (SEG !== 7'h7F) begin bad++; $display("FAIL reset_seg: SEG=%h expected 7f", SEG); end
    total++; if (siganl_input !== 1'b0) begin bad++; $display("FAIL reset_rxbusy: %b expected 0", siganl_input); end
    total++; if (siganl_out !== 1'b0) begin bad++; $display("FAIL reset_txbusy: %b expected 0", siganl_out); end
    for (int i = 0; i < 5; i++) begin
      tick(B);
      total++;
      if ({RsTx, siganl_input, siganl_out, AN, SEG} !== {3'b100, 8'hFF, 7'h7F}) begin
        bad++;
        $display("FAIL reset_hold bit %0d: tx=%b in=%b out=%b AN=%h SEG=%h", i, RsTx,
                 siganl_input, siganl_out, AN, SEG);
      end
    end
    rst_n = 1'b1;
    tick(2);
    total++;
    if ({AN, SEG} !== {8'hFE, 7'h40}) begin
      bad++;
      $display("FAIL reset_first_slot: AN=%h SEG=%h expected fe/40", AN, SEG);
    end
    $display("reset checked");
  endtask

  task automatic test_basic();
    send_str("1123");
    send_byte(8'h0D, 1'b1);
    check_display("basic_1123");
  endtask

  task automatic test_idle_reload();
    tick(200 * B);
    send_str("1193");
    send_byte(8'h0D, 1'b1);
    check_display("reload_1193");
    send_str("1010");
    send_byte(8'h0D, 1'b1);
    check_display("reload_1010");
    send_str("aBcDeF01");
    send_byte(8'h0D, 1'b1);
    check_display("mixed_case");
  endtask

`ifdef UART_ECHO_EN
  task automatic test_echo();
    send_str("1123");
    send_byte(8'h0D, 1'b1);
    check_display("echo_1123");
    tick(12 * B);
    total++;
    if (echo_q.size() != 0) begin
      bad++;
      $display("FAIL echo_drain: %0d bytes never echoed, expected 0", echo_q.size());
    end
  endtask

  // Decodes each frame on RsTx and pops the byte it should carry.
  initial begin : echo_mon
    logic       prev;
    logic [7:0] got;
    logic [7:0] exp_b;
    logic       stop_b;
    logic       start_ok;
    int         lat;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (prev === 1'b1 && RsTx === 1'b0) begin
        lat = cyc - stop_mid_cyc;
        repeat (B / 2) @(negedge clk);
        start_ok = (RsTx === 1'b0) && (siganl_out === 1'b1);
        for (int i = 0; i < 8; i++) begin
          repeat (B) @(negedge clk);
          got[i] = RsTx;
        end
        repeat (B) @(negedge clk);
        stop_b = RsTx;
        total++;
        if (echo_q.size() == 0) begin
          bad++;
          $display("FAIL echo_extra: unexpected byte %h on RsTx", got);
        end else begin
          exp_b = echo_q.pop_front();
          if ({start_ok, stop_b, got} !== {2'b11, exp_b} || lat < 0 || lat > 8) begin
            bad++;
            $display("FAIL echo_byte: got %h start_ok=%b stop=%b lat=%0d, expected %h lat<=8",
                     got, start_ok, stop_b, lat, exp_b);
          end
        end
        $display("tx frame %h latency %0d", got, lat);
      end
      prev = RsTx;
    end
  end
`else
  task automatic test_no_echo();
    bit viol;
    viol = 1'b0;
    send_byte(8'h5A, 1'b1);
    for (int i = 0; i < 12 * B; i++) begin
      @(negedge clk);
      if (RsTx !== 1'b1 || siganl_out !== 1'b0) viol = 1'b1;
    end
    total++;
    if (viol) begin
      bad++;
      $display("FAIL no_echo: RsTx/siganl_out active, expected 1/0 throughout");
    end
    $display("no-echo build checked");
  endtask
`endif

  task automatic test_overflow_errors();
    send_str("123456789A");
    send_byte(8'h0D, 1'b1);
    check_display("overflow");
    send_byte(8'h78, 1'b1);
    send_byte(8'h37, 1'b0);
    disp_q.push_back(32'h3456789A);
    check_display("ignored_bytes");
    send_byte(8'h0D, 1'b1);
    check_display("cr_after_bad_frame");
  endtask

  task automatic test_reset_mid();
    logic [7:0] b;
    b = 8'h37;
    tick(12 * B);
    RsRx = 1'b0;
    tick(B);
    for (int i = 0; i < 3; i++) begin
      RsRx = b[i];
      tick(B);
    end
    RsRx = b[3];
    tick(B / 2);
    rst_n = 1'b0;
    RsRx  = 1'b1;
    tick(2);
    total++;
    if ({siganl_input, RsTx} !== 2'b01) begin
      bad++;
      $display("FAIL mid_reset: siganl_input=%b RsTx=%b expected 0/1", siganl_input, RsTx);
    end
    rst_n = 1'b1;
    model_buf = '0;
    disp_q.push_back(32'h0);
    tick(2);
    check_display("after_mid_reset");
    send_byte(8'h35, 1'b1);
    send_byte(8'h0D, 1'b1);
    check_display("frame_after_reset");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_idle_reload();
`ifdef UART_ECHO_EN
    test_echo();
`else
    test_no_echo();
`endif
    test_overflow_errors();
    test_reset_mid();
`ifdef UART_ECHO_EN
    tick(12 * B);
    total++;
    if (echo_q.size() != 0) begin
      bad++;
      $display("FAIL final_echo_drain: %0d bytes pending, expected 0", echo_q.size());
    end
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
